// File: rtl/swi_debouncer.sv
// Two-flop synchroniser plus per-bit stability counter for the slide switches, with rise/fall pulses and a change counter.
// Latency: SWI_db follows a stable SWI change after 1+DEBOUNCE_CYCLES edges past capture; no backpressure, every output is a flop.
module swi_debouncer #(
   parameter int NBITS_TOP       = 8,
   parameter int DEBOUNCE_CYCLES = 3,
   parameter int NBITS_CNT       = 8
) (
   input  logic                 clk_2,
   input  logic                 reset_n,
   input  logic [NBITS_TOP-1:0] SWI,
   output logic [NBITS_TOP-1:0] SWI_db,
   output logic [NBITS_TOP-1:0] rise,
   output logic [NBITS_TOP-1:0] fall,
   output logic                 any_change,
   output logic [NBITS_CNT-1:0] change_count
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   generate
      if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_param
         $error("swi_debouncer: DEBOUNCE_CYCLES must be within 1..255");
      end
   endgenerate

   logic [NBITS_TOP-1:0] sync1_q, sync1_d;
   logic [NBITS_TOP-1:0] sync2_q, sync2_d;
   logic [NBITS_TOP-1:0] swi_db_q, swi_db_d;
   logic [CNT_W-1:0]     cnt_q [NBITS_TOP];
   logic [CNT_W-1:0]     cnt_d [NBITS_TOP];
   logic [NBITS_TOP-1:0] rise_q, rise_d;
   logic [NBITS_TOP-1:0] fall_q, fall_d;
   logic                 any_change_q, any_change_d;
   logic [NBITS_CNT-1:0] change_count_q, change_count_d;

   always_comb begin
      sync1_d        = SWI;
      sync2_d        = sync1_q;
      swi_db_d       = swi_db_q;
      cnt_d          = cnt_q;
      rise_d         = '0;
      fall_d         = '0;
      change_count_d = change_count_q;

      // Only sync2 is trusted; a run that breaks before completing restarts from zero.
      for (int i = 0; i < NBITS_TOP; i++) begin
         if (sync2_q[i] == swi_db_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            swi_db_d[i] = sync2_q[i];
            cnt_d[i]    = '0;
            rise_d[i]   = sync2_q[i];
            fall_d[i]   = ~sync2_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end

      any_change_d = |(rise_d | fall_d);
      if (any_change_d) begin
         change_count_d = change_count_q + NBITS_CNT'(1);
      end
   end

   always_ff @(posedge clk_2) begin
      if (!reset_n) begin
         sync1_q        <= '0;
         sync2_q        <= '0;
         swi_db_q       <= '0;
         cnt_q          <= '{default: '0};
         rise_q         <= '0;
         fall_q         <= '0;
         any_change_q   <= 1'b0;
         change_count_q <= '0;
      end else begin
         sync1_q        <= sync1_d;
         sync2_q        <= sync2_d;
         swi_db_q       <= swi_db_d;
         cnt_q          <= cnt_d;
         rise_q         <= rise_d;
         fall_q         <= fall_d;
         any_change_q   <= any_change_d;
         change_count_q <= change_count_d;
      end
   end

   assign SWI_db       = swi_db_q;
   assign rise         = rise_q;
   assign fall         = fall_q;
   assign any_change   = any_change_q;
   assign change_count = change_count_q;

endmodule

// File: tb/tb_swi_debouncer.sv
// Directed bench for swi_debouncer: expected pulses are queued at stimulus time and checked by a monitor.
module tb_swi_debouncer;

   localparam int D = 3;

   logic       clk_2 = 1'b0;
   logic       reset_n;
   logic [7:0] SWI;
   logic [7:0] SWI_db, rise, fall, change_count;
   logic       any_change;

   always #5 clk_2 = ~clk_2;

   swi_debouncer #(.NBITS_TOP(8), .DEBOUNCE_CYCLES(D), .NBITS_CNT(8)) dut (
      .clk_2       (clk_2),
      .reset_n     (reset_n),
      .SWI         (SWI),
      .SWI_db      (SWI_db),
      .rise        (rise),
      .fall        (fall),
      .any_change  (any_change),
      .change_count(change_count)
   );

   int cyc = 0;
   always @(posedge clk_2) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] r;
      logic [7:0] f;
      logic [7:0] db;
      logic [7:0] cnt;
      int         at;
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk_2);
   endtask

   // Drive a new stable value now and queue the single pulse it must produce D+2 edges later.
   task automatic step(input logic [7:0] v, input logic [7:0] er, input logic [7:0] ef,
                       input logic [7:0] ecnt);
      exp_t e;
      e.r   = er;
      e.f   = ef;
      e.db  = v;
      e.cnt = ecnt;
      e.at  = cyc + 2 + D;
      sb.push_back(e);
      SWI = v;
   endtask

   initial begin
      forever begin
         @(negedge clk_2);
         if (any_change === 1'b1 || (|(rise | fall)) === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_pulse", {rise, fall, 7'd0, any_change}, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("pulse_cycle", cyc, e.at);
               chk("rise", rise, e.r);
               chk("fall", fall, e.f);
               chk("any_change", any_change, 1'b1);
               chk("SWI_db", SWI_db, e.db);
               chk("change_count", change_count, e.cnt);
            end
         end
      end
   end

   initial begin
      reset_n = 1'b0;
      SWI     = 8'hFF;
      idle(2);
      chk("rst_SWI_db", SWI_db, 8'h00);
      chk("rst_rise", rise, 8'h00);
      chk("rst_fall", fall, 8'h00);
      chk("rst_any", any_change, 1'b0);
      chk("rst_count", change_count, 8'h00);

      // Switches already high at release appear as ordinary rises.
      reset_n = 1'b1;
      step(8'hFF, 8'hFF, 8'h00, 8'd1);
      idle(D + 1);
      chk("latency_not_yet", SWI_db, 8'h00);
      idle(4);

      step(8'h00, 8'h00, 8'hFF, 8'd2);
      idle(8);

      step(8'h05, 8'h05, 8'h00, 8'd3);
      idle(6);
      chk("step_rise_cleared", rise, 8'h00);
      chk("step_fall_zero", fall, 8'h00);
      chk("step_any_cleared", any_change, 1'b0);
      idle(2);

      SWI = 8'h0D; idle(1);
      SWI = 8'h05; idle(1);
      SWI = 8'h0D; idle(1);
      SWI = 8'h05; idle(1);
      step(8'h0D, 8'h08, 8'h00, 8'd4);
      idle(D + 1);
      chk("bounce_not_yet", SWI_db, 8'h05);
      idle(5);

      SWI = 8'h8D;
      idle(D - 1);
      SWI = 8'h0D;
      idle(8);
      chk("glitch_SWI_db", SWI_db, 8'h0D);
      chk("glitch_count", change_count, 8'd4);

      step(8'h0F, 8'h02, 8'h00, 8'd5);
      idle(8);
      step(8'hF0, 8'hF0, 8'h0F, 8'd6);
      idle(8);

      // Reset lands on the edge that would otherwise accept the fall.
      SWI = 8'h00;
      idle(D + 1);
      reset_n = 1'b0;
      idle(2);
      chk("midrst_SWI_db", SWI_db, 8'h00);
      chk("midrst_rise", rise, 8'h00);
      chk("midrst_fall", fall, 8'h00);
      chk("midrst_any", any_change, 1'b0);
      chk("midrst_count", change_count, 8'h00);
      reset_n = 1'b1;
      idle(10);
      chk("postrst_SWI_db", SWI_db, 8'h00);
      chk("postrst_count", change_count, 8'h00);

      step(8'h01, 8'h01, 8'h00, 8'd1);
      idle(8);

      for (int i = 0; i < 255; i++) begin
         if (i % 2 == 0) step(8'h00, 8'h00, 8'h01, 8'((2 + i) % 256));
         else            step(8'h01, 8'h01, 8'h00, 8'((2 + i) % 256));
         idle(D + 3);
      end
      idle(8);
      chk("wrap_count", change_count, 8'h00);
      chk("wrap_SWI_db", SWI_db, 8'h00);

      for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
      chk("scoreboard_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/swi_debouncer.md
Name: swi_debouncer

Overview:
- Upstream conditioning stage for the board's combinational logic stage. It takes the raw slide switches SWI and produces clean, debounced copies for that stage.
- Each bit is synchronised by two flops and then debounced by its own stability counter.
- The block also emits one-cycle rise/fall pulses per bit and a wrapping count of accepted change events. The count can be shown on lcd_* or LED for debug.

Parameters:
NBITS_TOP, 8, width of switch bus
DEBOUNCE_CYCLES, 3, consecutive clk_2 cycles a synchronised bit must differ from its debounced value before it is accepted; legal range 1..255
NBITS_CNT, 8, width of change_count

Ports:
clk_2  input  1  the single clock; all state updates on its rising edge
reset_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk_2
SWI  input  NBITS_TOP  raw, asynchronous, bouncing switches
SWI_db  output  NBITS_TOP  debounced switch values, consumed by the combinational stage in place of SWI
rise  output  NBITS_TOP  bit i high for exactly one cycle when SWI_db[i] goes 0->1
fall  output  NBITS_TOP  bit i high for exactly one cycle when SWI_db[i] goes 1->0
any_change  output  1  OR of rise|fall
change_count  output  NBITS_CNT  number of cycles in which any_change was high; wraps

Behaviour:
- One clock; reset is synchronous and active-low (clk_2, reset_n).
- Reset: reset_n low at an edge clears the following to 0: sync1, sync2, SWI_db, all per-bit counters, rise, fall, any_change and change_count. Reset has priority over every other event.
- Reset mid-debounce discards partial counts; no pulse is produced.
- Switches that are high when reset releases are detected as normal 0->1 transitions after full latency. This is intentional.
- Synchroniser: sync1 <= SWI and sync2 <= sync1 on every edge. Only sync2 is used downstream.
- Per-bit counter cnt[i]: width max(1, clog2(DEBOUNCE_CYCLES)). At each edge, for each bit:
  - sync2[i] == SWI_db[i]: cnt[i] <= 0; no change.
  - sync2[i] != SWI_db[i] and cnt[i] == DEBOUNCE_CYCLES-1: SWI_db[i] <= sync2[i]; cnt[i] <= 0; rise[i] or fall[i] <= 1 according to direction.
  - sync2[i] != SWI_db[i] otherwise: cnt[i] <= cnt[i]+1.
- Glitch rejection: if sync2[i] returns to SWI_db[i] before the count completes, the counter clears. The next differing run restarts from 0.
- rise and fall are registered and default to 0 every cycle. They are high only in the cycle following the accepting edge, aligned with the new SWI_db. rise[i] and fall[i] are never high together.
- Latency: SWI stable and changed before edge k means SWI_db updates at edge k+1+DEBOUNCE_CYCLES. With the default, SWI_db updates at edge k+4.
- any_change is registered: it reflects |(rise|fall) in the same cycle as the pulses, with no extra delay.
- change_count: increments by exactly 1 at the edge that sets any_change, regardless of how many bits changed simultaneously. Wraps from 2^NBITS_CNT-1 to 0.
- Bits are fully independent. Simultaneous changes on several bits in the same cycle are accepted in the same cycle.
- No combinational path from SWI to any output. All outputs are flops.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with SWI=8'hFF -> all outputs 0. Release at edge r -> SWI_db=8'hFF, rise=8'hFF and any_change=1 after edge r+4; change_count=1.
- Clean step: SWI 8'h00 -> 8'h05 before edge k -> SWI_db=8'h05 after edge k+4; rise=8'h05 for one cycle only; fall=0; change_count +1.
- Bounce: SWI[3] toggles 1,0,1,0 on successive cycles, then holds 1 -> no pulse during the toggling; SWI_db[3]=1 exactly 4 edges after the final stable value reaches SWI.
- Short glitch: SWI[7] goes high for 2 cycles then low -> SWI_db stays 8'h00; rise, fall and change_count are unchanged.
- Simultaneous/opposite: from SWI_db=8'h0F, drive SWI=8'hF0 -> one cycle with rise=8'hF0, fall=8'h0F and any_change=1; change_count increments by exactly 1.
- Wrap and mid-operation reset: force 256 accepted changes -> change_count reads 0. Assert reset_n=0 two cycles into a debounce -> counts cleared and no pulse; the count restarts after release.
